// File: rtl/sram_arbiter.sv
// sram_arbiter: shares one SRAM-like memory port between the instruction-fetch
// requester (read-only) and the data requester (load/store). One transaction is
// in flight at a time; arbitration happens only in IDLE, never mid-transaction.
//
// Ports:
//   clk, reset           clock, synchronous active-high reset
//   inst_*               fetch requester (req/addr in, addr_ok/data_ok/rdata out)
//   data_*               data requester (req/wr/size/wstrb/addr/wdata in,
//                        addr_ok/data_ok/rdata out)
//   mem_*                shared memory port (req/wr/size/wstrb/addr/wdata out,
//                        addr_ok/data_ok/rdata in)
//   busy                 arbiter is not IDLE
//
// Configuration:
//   SRAM_ARB_RR_EN       defined: round-robin on simultaneous requests (the
//                        requester that was not served last wins).
//                        undefined: fixed priority, data over inst.
module sram_arbiter #(
  parameter int unsigned ADDR_W = 32,
  parameter int unsigned DATA_W = 32
) (
  input  logic                clk,
  input  logic                reset,

  input  logic                inst_req,
  input  logic [ADDR_W-1:0]   inst_addr,
  output logic                inst_addr_ok,
  output logic                inst_data_ok,
  output logic [DATA_W-1:0]   inst_rdata,

  input  logic                data_req,
  input  logic                data_wr,
  input  logic [1:0]          data_size,
  input  logic [DATA_W/8-1:0] data_wstrb,
  input  logic [ADDR_W-1:0]   data_addr,
  input  logic [DATA_W-1:0]   data_wdata,
  output logic                data_addr_ok,
  output logic                data_data_ok,
  output logic [DATA_W-1:0]   data_rdata,

  output logic                mem_req,
  output logic                mem_wr,
  output logic [1:0]          mem_size,
  output logic [DATA_W/8-1:0] mem_wstrb,
  output logic [ADDR_W-1:0]   mem_addr,
  output logic [DATA_W-1:0]   mem_wdata,
  input  logic                mem_addr_ok,
  input  logic                mem_data_ok,
  input  logic [DATA_W-1:0]   mem_rdata,

  output logic                busy
);

  localparam int unsigned STRB_W = DATA_W / 8;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_ADDR = 2'd1,
    ST_DATA = 2'd2
  } state_e;

  typedef enum logic {
    GNT_INST = 1'b0,
    GNT_DATA = 1'b1
  } grant_e;

  state_e state_q;
  grant_e grant_q;
`ifdef SRAM_ARB_RR_EN
  grant_e last_grant_q;
`endif

  grant_e pick_c;
  logic   gnt_data_c;
  logic   gnt_req_c;
  logic   in_addr_c;
  logic   in_data_c;

  // Arbitration winner, only consumed in IDLE.
  always_comb begin
    pick_c = GNT_INST;
`ifdef SRAM_ARB_RR_EN
    if (data_req && inst_req) begin
      pick_c = (last_grant_q == GNT_DATA) ? GNT_INST : GNT_DATA;
    end else if (data_req) begin
      pick_c = GNT_DATA;
    end
`else
    if (data_req) begin
      pick_c = GNT_DATA;
    end
`endif
  end

  assign gnt_data_c = (grant_q == GNT_DATA);
  assign gnt_req_c  = gnt_data_c ? data_req : inst_req;

  // Phase qualifiers are forced low during reset so every handshake output
  // reads 0 while reset is held, even before the state register has cleared.
  assign in_addr_c = !reset && (state_q == ST_ADDR);
  assign in_data_c = !reset && (state_q == ST_DATA);

  // Arbiter FSM: state, current grant and (optionally) last served requester.
  always_ff @(posedge clk) begin
    if (reset) begin
      state_q      <= ST_IDLE;
      grant_q      <= GNT_INST;
`ifdef SRAM_ARB_RR_EN
      last_grant_q <= GNT_INST;
`endif
    end else begin
      case (state_q)
        ST_IDLE: begin
          if (inst_req || data_req) begin
            grant_q <= pick_c;
            state_q <= ST_ADDR;
          end
        end
        ST_ADDR: begin
          // A requester that withdraws before acceptance gets no transaction.
          if (!gnt_req_c) begin
            state_q <= ST_IDLE;
          end else if (mem_addr_ok) begin
            state_q <= ST_DATA;
          end
        end
        ST_DATA: begin
          if (mem_data_ok) begin
            state_q      <= ST_IDLE;
`ifdef SRAM_ARB_RR_EN
            last_grant_q <= grant_q;
`endif
          end
        end
        default: begin
          state_q <= ST_IDLE;
        end
      endcase
    end
  end

  // Memory request side: driven only while presenting an address.
  assign mem_req   = in_addr_c && gnt_req_c;
  assign mem_wr    = in_addr_c && gnt_data_c && data_wr;
  assign mem_size  = !in_addr_c ? 2'd0 : (gnt_data_c ? data_size : 2'd2);
  assign mem_wstrb = (in_addr_c && gnt_data_c) ? data_wstrb : STRB_W'(0);
  assign mem_addr  = !in_addr_c ? ADDR_W'(0) : (gnt_data_c ? data_addr : inst_addr);
  assign mem_wdata = (in_addr_c && gnt_data_c) ? data_wdata : DATA_W'(0);

  // Handshake routing to the granted requester only.
  assign inst_addr_ok = mem_req && mem_addr_ok && !gnt_data_c;
  assign data_addr_ok = mem_req && mem_addr_ok &&  gnt_data_c;
  assign inst_data_ok = in_data_c && mem_data_ok && !gnt_data_c;
  assign data_data_ok = in_data_c && mem_data_ok &&  gnt_data_c;

  // Read data is shared; the granted data_ok alone qualifies it.
  assign inst_rdata = mem_rdata;
  assign data_rdata = mem_rdata;

  assign busy = !reset && (state_q != ST_IDLE);

endmodule

// File: tb/tb_sram_arbiter.sv
// Directed bench for sram_arbiter with a response scoreboard: the expected
// responder and read data are queued when a request is issued and checked when
// a *_data_ok appears.
module tb_sram_arbiter;

  localparam int unsigned ADDR_W = 32;
  localparam int unsigned DATA_W = 32;

  localparam logic [31:0] IA_S = 32'h1c00_1000;
  localparam logic [31:0] DA_S = 32'h1c00_8040;

  logic              clk = 1'b0;
  logic              reset;
  logic              inst_req;
  logic [ADDR_W-1:0] inst_addr;
  logic              inst_addr_ok, inst_data_ok;
  logic [DATA_W-1:0] inst_rdata;
  logic              data_req, data_wr;
  logic [1:0]        data_size;
  logic [3:0]        data_wstrb;
  logic [ADDR_W-1:0] data_addr;
  logic [DATA_W-1:0] data_wdata;
  logic              data_addr_ok, data_data_ok;
  logic [DATA_W-1:0] data_rdata;
  logic              mem_req, mem_wr;
  logic [1:0]        mem_size;
  logic [3:0]        mem_wstrb;
  logic [ADDR_W-1:0] mem_addr;
  logic [DATA_W-1:0] mem_wdata;
  logic              mem_addr_ok, mem_data_ok;
  logic [DATA_W-1:0] mem_rdata;
  logic              busy;

  typedef struct packed {
    logic        is_data;
    logic [31:0] rdata;
  } exp_t;

  exp_t sb_q[$];
  int   n_tests = 0;
  int   n_fail  = 0;
  logic last_is_data = 1'b0;

  sram_arbiter #(.ADDR_W(ADDR_W), .DATA_W(DATA_W)) dut (
    .clk(clk), .reset(reset),
    .inst_req(inst_req), .inst_addr(inst_addr),
    .inst_addr_ok(inst_addr_ok), .inst_data_ok(inst_data_ok), .inst_rdata(inst_rdata),
    .data_req(data_req), .data_wr(data_wr), .data_size(data_size),
    .data_wstrb(data_wstrb), .data_addr(data_addr), .data_wdata(data_wdata),
    .data_addr_ok(data_addr_ok), .data_data_ok(data_data_ok), .data_rdata(data_rdata),
    .mem_req(mem_req), .mem_wr(mem_wr), .mem_size(mem_size), .mem_wstrb(mem_wstrb),
    .mem_addr(mem_addr), .mem_wdata(mem_wdata),
    .mem_addr_ok(mem_addr_ok), .mem_data_ok(mem_data_ok), .mem_rdata(mem_rdata),
    .busy(busy)
  );

  always #5 clk = ~clk;

  task automatic nxt();
    @(posedge clk);
    #1;
  endtask

  task automatic smp();
    #1;
  endtask

  task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_tests++;
    assert (obs === exp) else begin
      n_fail++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  // Pops the scoreboard and checks the response visible at this sample point.
  task automatic resp_check(input string tag);
    exp_t e;
    n_tests++;
    assert (sb_q.size() != 0) else begin
      n_fail++;
      $error("FAIL %s_sb: observed empty scoreboard expected a pending entry", tag);
    end
    if (sb_q.size() != 0) begin
      e = sb_q.pop_front();
      chk({tag, "_valid"}, 64'(inst_data_ok | data_data_ok), 64'(1));
      chk({tag, "_data_ok"}, 64'(data_data_ok), 64'(e.is_data));
      chk({tag, "_inst_ok"}, 64'(inst_data_ok), 64'(!e.is_data));
      chk({tag, "_rdata"}, 64'(e.is_data ? data_rdata : inst_rdata), 64'(e.rdata));
    end
  endtask

  // Serves one already-requested read for the expected requester; caller is at
  // an IDLE sample point with the request(s) held.
  task automatic serve(input string tag, input logic is_data, input logic [31:0] rd);
    nxt();
    mem_addr_ok = 1'b1;
    smp();
    chk({tag, "_mreq"}, 64'(mem_req), 64'(1));
    chk({tag, "_maddr"}, 64'(mem_addr), 64'(is_data ? DA_S : IA_S));
    chk({tag, "_mwr"}, 64'(mem_wr), 64'(0));
    chk({tag, "_aok_win"}, 64'(is_data ? data_addr_ok : inst_addr_ok), 64'(1));
    chk({tag, "_aok_lose"}, 64'(is_data ? inst_addr_ok : data_addr_ok), 64'(0));
    nxt();
    mem_addr_ok = 1'b0;
    if (is_data) data_req = 1'b0; else inst_req = 1'b0;
    smp();
    chk({tag, "_data_mreq"}, 64'(mem_req), 64'(0));
    nxt();
    mem_data_ok = 1'b1;
    mem_rdata   = rd;
    smp();
    resp_check(tag);
    chk({tag, "_resp_aok_lose"}, 64'(is_data ? inst_addr_ok : data_addr_ok), 64'(0));
    last_is_data = is_data;
    nxt();
    mem_data_ok = 1'b0;
    smp();
    chk({tag, "_bubble_busy"}, 64'(busy), 64'(0));
    chk({tag, "_bubble_mreq"}, 64'(mem_req), 64'(0));
  endtask

  // Issues simultaneous reads and expects them in arbitration order.
  task automatic both_round(input string tag);
    logic first_data;
`ifdef SRAM_ARB_RR_EN
    first_data = !last_is_data;
`else
    first_data = 1'b1;
`endif
    nxt();
    inst_req = 1'b1; inst_addr = IA_S;
    data_req = 1'b1; data_wr = 1'b0; data_size = 2'd2; data_wstrb = 4'h0;
    data_addr = DA_S; data_wdata = 32'h0;
    sb_q.push_back('{is_data: first_data, rdata: 32'hA000_0001});
    sb_q.push_back('{is_data: !first_data, rdata: 32'hB000_0002});
    smp();
    serve({tag, "_first"}, first_data, 32'hA000_0001);
    serve({tag, "_second"}, !first_data, 32'hB000_0002);
  endtask

  initial begin
    reset = 1'b1;
    inst_req = 1'b0; inst_addr = '0;
    data_req = 1'b0; data_wr = 1'b0; data_size = 2'd0; data_wstrb = 4'h0;
    data_addr = '0; data_wdata = '0;
    mem_addr_ok = 1'b0; mem_data_ok = 1'b0; mem_rdata = 32'h1234_5678;

    // Reset state, including a stray memory response while in reset.
    nxt(); nxt();
    mem_data_ok = 1'b1;
    smp();
    chk("rst_mem_req", 64'(mem_req), 64'(0));
    chk("rst_busy", 64'(busy), 64'(0));
    chk("rst_inst_aok", 64'(inst_addr_ok), 64'(0));
    chk("rst_data_aok", 64'(data_addr_ok), 64'(0));
    chk("rst_inst_dok", 64'(inst_data_ok), 64'(0));
    chk("rst_data_dok", 64'(data_data_ok), 64'(0));
    chk("rst_inst_rdata", 64'(inst_rdata), 64'(32'h1234_5678));
    chk("rst_data_rdata", 64'(data_rdata), 64'(32'h1234_5678));
    nxt();
    reset = 1'b0;
    mem_data_ok = 1'b0;
    smp();

    // Inst-only read.
    nxt();
    inst_req = 1'b1; inst_addr = 32'h1c00_0000;
    sb_q.push_back('{is_data: 1'b0, rdata: 32'h0280_0c0c});
    smp();
    chk("t1_idle_mreq", 64'(mem_req), 64'(0));
    nxt();
    mem_addr_ok = 1'b1;
    smp();
    chk("t1_mreq", 64'(mem_req), 64'(1));
    chk("t1_maddr", 64'(mem_addr), 64'(32'h1c00_0000));
    chk("t1_mwr", 64'(mem_wr), 64'(0));
    chk("t1_msize", 64'(mem_size), 64'(2));
    chk("t1_mwstrb", 64'(mem_wstrb), 64'(0));
    chk("t1_inst_aok", 64'(inst_addr_ok), 64'(1));
    chk("t1_data_aok", 64'(data_addr_ok), 64'(0));
    chk("t1_busy", 64'(busy), 64'(1));
    nxt();
    inst_req = 1'b0; mem_addr_ok = 1'b0;
    smp();
    chk("t1_wait_mreq", 64'(mem_req), 64'(0));
    chk("t1_wait_aok", 64'(inst_addr_ok), 64'(0));
    chk("t1_wait_dok", 64'(inst_data_ok), 64'(0));
    nxt();
    smp();
    chk("t1_wait2_dok", 64'(inst_data_ok), 64'(0));
    nxt();
    mem_data_ok = 1'b1; mem_rdata = 32'h0280_0c0c;
    smp();
    resp_check("t1_resp");
    nxt();
    mem_data_ok = 1'b0;
    smp();
    chk("t1_end_busy", 64'(busy), 64'(0));
    chk("t1_end_dok", 64'(inst_data_ok), 64'(0));

    // Data write with the memory accepting the address three cycles late.
    nxt();
    data_req = 1'b1; data_wr = 1'b1; data_size = 2'd2; data_wstrb = 4'hF;
    data_addr = 32'h1c00_8000; data_wdata = 32'hdead_beef; mem_rdata = 32'h0;
    sb_q.push_back('{is_data: 1'b1, rdata: 32'h0});
    smp();
    for (int i = 0; i < 3; i++) begin
      nxt();
      smp();
      chk($sformatf("t2_hold%0d_mreq", i), 64'(mem_req), 64'(1));
      chk($sformatf("t2_hold%0d_aok", i), 64'(data_addr_ok), 64'(0));
    end
    chk("t2_mwr", 64'(mem_wr), 64'(1));
    chk("t2_msize", 64'(mem_size), 64'(2));
    chk("t2_mwstrb", 64'(mem_wstrb), 64'(4'hF));
    chk("t2_maddr", 64'(mem_addr), 64'(32'h1c00_8000));
    chk("t2_mwdata", 64'(mem_wdata), 64'(32'hdead_beef));
    nxt();
    mem_addr_ok = 1'b1;
    smp();
    chk("t2_acc_mreq", 64'(mem_req), 64'(1));
    chk("t2_acc_data_aok", 64'(data_addr_ok), 64'(1));
    chk("t2_acc_inst_aok", 64'(inst_addr_ok), 64'(0));
    nxt();
    data_req = 1'b0; data_wr = 1'b0; mem_addr_ok = 1'b0;
    smp();
    chk("t2_wait_mreq", 64'(mem_req), 64'(0));
    chk("t2_wait_aok", 64'(data_addr_ok), 64'(0));
    nxt();
    mem_data_ok = 1'b1;
    smp();
    resp_check("t2_resp");
    last_is_data = 1'b1;
    nxt();
    mem_data_ok = 1'b0;
    smp();
    chk("t2_end_busy", 64'(busy), 64'(0));

    // Simultaneous requests, twice.
    both_round("t3a");
    both_round("t3b");

    // Reset while waiting in DATA; the late response must be dropped.
    nxt();
    inst_req = 1'b1; inst_addr = IA_S;
    smp();
    nxt();
    mem_addr_ok = 1'b1;
    smp();
    chk("t4_aok", 64'(inst_addr_ok), 64'(1));
    nxt();
    inst_req = 1'b0; mem_addr_ok = 1'b0; reset = 1'b1;
    smp();
    chk("t4_rst_mreq", 64'(mem_req), 64'(0));
    nxt();
    reset = 1'b0; mem_data_ok = 1'b1; mem_rdata = 32'h5555_aaaa;
    smp();
    chk("t4_post_inst_dok", 64'(inst_data_ok), 64'(0));
    chk("t4_post_data_dok", 64'(data_data_ok), 64'(0));
    chk("t4_post_busy", 64'(busy), 64'(0));
    chk("t4_post_mreq", 64'(mem_req), 64'(0));
    nxt();
    mem_data_ok = 1'b0;
    last_is_data = 1'b0;
    smp();

    // Request withdrawn while presenting the address.
    nxt();
    inst_req = 1'b1; inst_addr = IA_S;
    smp();
    nxt();
    smp();
    chk("t5_mreq", 64'(mem_req), 64'(1));
    inst_req = 1'b0; mem_addr_ok = 1'b1;
    smp();
    chk("t5_drop_mreq", 64'(mem_req), 64'(0));
    chk("t5_drop_aok", 64'(inst_addr_ok), 64'(0));
    nxt();
    mem_addr_ok = 1'b0;
    smp();
    chk("t5_idle_busy", 64'(busy), 64'(0));
    nxt();
    mem_data_ok = 1'b1;
    smp();
    chk("t5_stray_inst_dok", 64'(inst_data_ok), 64'(0));
    chk("t5_stray_data_dok", 64'(data_data_ok), 64'(0));
    nxt();
    mem_data_ok = 1'b0;
    smp();

    chk("sb_drained", 64'(sb_q.size()), 64'(0));

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule
